// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store access controller between the core and a
// single-ported data memory. Checks alignment/funct3 legality, steers store
// lanes, runs one memory transfer with a bounded ack wait, and reports the
// outcome with a one-cycle done pulse.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_req,
   input  logic        st_req,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] daddr,
   output logic [31:0] drdata,
   output logic [1:0]  fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        req;
   logic        op_ld;
   logic [7:0]  cnt;
   logic        timeout_hit;
   logic [1:0]  req_fault;
   logic [3:0]  be_nxt;
   logic [31:0] wd_nxt;

   assign req         = ld_req | st_req;
   assign timeout_hit = (cnt == CNT_LAST);

   // Request legality: an unusable funct3 outranks misalignment.
   always_comb begin
      req_fault = 2'b00;
      if (funct3[1:0] == 2'b11)
         req_fault = 2'b11;
      else if (!ld_req && funct3[2])
         req_fault = 2'b11;
      else if (ld_req && funct3 == 3'b110)
         req_fault = 2'b11;
      else if (funct3[1:0] == 2'b01 && addr[0])
         req_fault = 2'b01;
      else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
         req_fault = 2'b01;
   end

   // Store lane steering; loads always read the full word.
   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = wdata;
      if (!ld_req) begin
         case (funct3[1:0])
            2'b00: begin
               be_nxt = 4'b0001 << addr[1:0];
               wd_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_nxt = 4'b0011 << addr[1:0];
               wd_nxt = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and the combinational stall.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         S_IDLE: begin
            stall = req;
            if (req) state_nxt = (req_fault != 2'b00) ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            stall = 1'b1;
            if (mem_ack || timeout_hit) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture, memory-side registers, timeout counter and completion status.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_ld     <= 1'b0;
         cnt       <= 8'd0;
         done      <= 1'b0;
         daddr     <= 32'd0;
         drdata    <= 32'd0;
         fault     <= 2'b00;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
      end else begin
         done <= (state_nxt == S_DONE);
         case (state)
            S_IDLE: begin
               if (req) begin
                  op_ld <= ld_req;
                  daddr <= addr;
                  if (req_fault != 2'b00) begin
                     fault  <= req_fault;
                     drdata <= 32'd0;
                  end else begin
                     fault     <= 2'b00;
                     cnt       <= 8'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= ~ld_req;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_be    <= be_nxt;
                     mem_wdata <= wd_nxt;
                  end
               end
            end
            S_ACCESS: begin
               // ack is checked first so it wins over the timeout limit
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  fault   <= 2'b00;
                  if (op_ld) drdata <= mem_rdata;
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  fault   <= 2'b10;
                  drdata  <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a transaction-level model.
module tb_dmem_access_ctrl;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset, ld_req, st_req, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, mem_rdata;
   logic        stall, done, mem_req, mem_we;
   logic [31:0] daddr, drdata, mem_addr, mem_wdata;
   logic [1:0]  fault;
   logic [3:0]  mem_be;

   int ntests = 0, nfail = 0;
   logic [31:0] m_daddr = 0, m_drdata = 0;

   dmem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ld_req(ld_req), .st_req(st_req),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .done(done), .daddr(daddr), .drdata(drdata), .fault(fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fault code from the ISA rules: size from funct3[1:0], legal opcode sets, natural alignment.
   function automatic logic [1:0] ref_fault(input bit is_ld, input logic [2:0] f, input logic [31:0] a);
      int sz;
      sz = int'(f[1:0]);
      if (sz == 3) return 2'b11;
      if (is_ld && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b11;
      if (!is_ld && f > 3'd2) return 2'b11;
      if ((a % (32'd1 << sz)) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] ref_be(input bit is_ld, input logic [2:0] f, input logic [31:0] a);
      int nb;
      if (is_ld) return 4'hF;
      nb = 1 << int'(f[1:0]);
      if (nb >= 4) return 4'hF;
      return 4'(((1 << nb) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] ref_wd(input logic [2:0] f, input logic [31:0] w);
      case (f[1:0])
         2'd0:    return {24'd0, w[7:0]} * 32'h01010101;
         2'd1:    return {16'd0, w[15:0]} * 32'h00010001;
         default: return w;
      endcase
   endfunction

   // One request: idle slot, request cycle, ACCESS cycles (ack at ack_at, none if >= TO), done.
   task automatic txn(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] w, input int ack_at, input logic [31:0] rd);
      logic [1:0] ef;
      bit is_ld;
      is_ld = ld;
      ef = ref_fault(is_ld, f, a);
      step();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_mreq", 32'(mem_req), 32'd0);
      mem_ack = 1'($urandom % 2);          // stray acks outside ACCESS are ignored
      mem_rdata = $urandom;
      #1 chk("idle_stall", 32'(stall), 32'd0);
      ld_req = ld; st_req = st; funct3 = f; addr = a; wdata = w;
      #1 chk("req_stall", 32'(stall), 32'd1);
      step();
      m_daddr = a;
      if (ef != 2'b00) begin
         m_drdata = 0;
      end else begin
         for (int k = 0; k < TO; k++) begin
            chk("acc_mreq", 32'(mem_req), 32'd1);
            chk("acc_we", 32'(mem_we), 32'(!is_ld));
            chk("acc_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("acc_be", 32'(mem_be), 32'(ref_be(is_ld, f, a)));
            if (!is_ld) chk("acc_wdata", mem_wdata, ref_wd(f, w));
            chk("acc_stall", 32'(stall), 32'd1);
            chk("acc_done", 32'(done), 32'd0);
            mem_ack = (k == ack_at);
            mem_rdata = (k == ack_at) ? rd : $urandom;
            step();
            if (k == ack_at) begin
               if (is_ld) m_drdata = rd;
               break;
            end
            if (k == TO - 1) begin
               ef = 2'b10;
               m_drdata = 0;
            end
         end
         mem_ack = 0;
      end
      chk("done", 32'(done), 32'd1);
      chk("fault", 32'(fault), 32'(ef));
      chk("end_mreq", 32'(mem_req), 32'd0);
      chk("drdata", drdata, m_drdata);
      chk("daddr", daddr, m_daddr);
      chk("done_stall", 32'(stall), 32'd0);
      ld_req = 0; st_req = 0;
   endtask

   initial begin
      int r, ack_at;
      bit ld, st;
      logic [31:0] a;
      reset = 1; ld_req = 0; st_req = 0; funct3 = 0; addr = 0; wdata = 0;
      mem_rdata = 0; mem_ack = 0;
      step(); step();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mreq", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_daddr", daddr, 32'd0);
      chk("rst_drdata", drdata, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      reset = 0;

      txn(1, 0, 3'b010, 32'h08, 32'h0, 0, 32'hA5A5A5A5);   // LW, ack first cycle
      txn(0, 1, 3'b000, 32'h13, 32'hC3, 2, 32'h0);         // SB upper lane
      txn(0, 1, 3'b001, 32'h22, 32'h1234BEEF, 1, 32'h0);   // SH upper half
      txn(1, 0, 3'b001, 32'h05, 32'h0, 0, 32'h0);          // LH misaligned
      txn(1, 0, 3'b011, 32'h00, 32'h0, 0, 32'h0);          // illegal funct3
      txn(0, 1, 3'b100, 32'h00, 32'h0, 0, 32'h0);          // store funct3 100
      txn(1, 0, 3'b010, 32'h40, 32'h0, TO, 32'h0);         // timeout
      txn(1, 0, 3'b010, 32'h44, 32'h0, TO - 1, 32'h600DF00D); // ack on last cycle
      txn(1, 1, 3'b100, 32'h31, 32'h0, 0, 32'h000000FF);   // both high: load wins

      // reset on the second ACCESS cycle aborts without a done pulse
      step();
      ld_req = 1; funct3 = 3'b010; addr = 32'h50; mem_ack = 0;
      step();
      chk("ra_mreq0", 32'(mem_req), 32'd1);
      step();
      chk("ra_mreq1", 32'(mem_req), 32'd1);
      reset = 1; ld_req = 0;
      step();
      chk("ra_mreq_off", 32'(mem_req), 32'd0);
      chk("ra_done", 32'(done), 32'd0);
      chk("ra_drdata", drdata, 32'd0);
      reset = 0; m_daddr = 0; m_drdata = 0;
      step();
      chk("ra_done_after", 32'(done), 32'd0);
      txn(1, 0, 3'b010, 32'h54, 32'h0, 1, 32'hCAFEBABE);

      for (int n = 0; n < 300; n++) begin
         ld = 1'($urandom % 2);
         st = ld ? 1'($urandom % 2) : 1'b1;
         a = $urandom;
         if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
         r = int'($urandom % 10);
         if (r < 6)       ack_at = int'($urandom % 4);
         else if (r < 8)  ack_at = int'($urandom % TO);
         else if (r == 8) ack_at = TO - 1;
         else             ack_at = TO;
         txn(ld, st, 3'($urandom % 8), a, $urandom, ack_at, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
